// File: rtl/hwpf_arbiter_if.sv
// rtl/hwpf_arbiter_if.sv - request bundle between CPU, prefetch FIFO, arbiter and dcache
// Carries the shared request type plus all handshake/payload signals of the arbiter.
typedef struct packed {
  logic        valid;
  logic [31:0] addr;
  logic [4:0]  rd;
  logic [63:0] data_rs1;
} req_cpu_dcache_t;

interface hwpf_arbiter_if;
  logic            cpu_req_valid_i;
  req_cpu_dcache_t cpu_req_i;
  logic            cpu_req_ready_o;
  logic            pf_req_valid_i;
  req_cpu_dcache_t pf_req_i;
  logic            pf_read_o;
  logic            dcache_req_valid_o;
  req_cpu_dcache_t dcache_req_o;
  logic            dcache_req_src_pf_o;
  logic            dcache_req_ready_i;

  modport master (
    input  cpu_req_valid_i, cpu_req_i, pf_req_valid_i, pf_req_i, dcache_req_ready_i,
    output cpu_req_ready_o, pf_read_o, dcache_req_valid_o, dcache_req_o, dcache_req_src_pf_o
  );

  modport slave (
    output cpu_req_valid_i, cpu_req_i, pf_req_valid_i, pf_req_i, dcache_req_ready_i,
    input  cpu_req_ready_o, pf_read_o, dcache_req_valid_o, dcache_req_o, dcache_req_src_pf_o
  );
endinterface

// File: rtl/hwpf_arbiter.sv
// rtl/hwpf_arbiter.sv - CPU-vs-prefetch arbiter with one-entry output register
// Demand requests win unless a prefetch has lost STARVE_MAX arbitrations in a row.
module hwpf_arbiter #(
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  flush_i,
  hwpf_arbiter_if.master        bus,
  output logic [31:0]           pf_issued_cnt_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {EMPTY, HOLD_CPU, HOLD_PF} state_t;

  state_t          state, state_next;
  req_cpu_dcache_t req_q, req_next;
  logic [SW-1:0]   starve_cnt;
  logic            load_en, pf_win, cpu_win, starved;

  assign starved = (starve_cnt == SW'(STARVE_MAX));
  assign load_en = (state == EMPTY) | bus.dcache_req_ready_i;
  assign pf_win  = bus.pf_req_valid_i & enable_i & ~flush_i & (~bus.cpu_req_valid_i | starved);
  assign cpu_win = bus.cpu_req_valid_i & ~pf_win;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= EMPTY;
      req_q <= '0;
    end else begin
      state <= state_next;
      req_q <= req_next;
    end
  end

  // Strobes are gated by reset so nothing is popped or accepted while held in reset.
  always_comb begin
    state_next          = state;
    req_next            = req_q;
    bus.cpu_req_ready_o = 1'b0;
    bus.pf_read_o       = 1'b0;
    if (load_en) begin
      bus.cpu_req_ready_o = cpu_win & rst_ni;
      bus.pf_read_o       = pf_win & rst_ni;
      if (pf_win) begin
        state_next     = HOLD_PF;
        req_next       = bus.pf_req_i;
        req_next.valid = 1'b1;
      end else if (cpu_win) begin
        state_next     = HOLD_CPU;
        req_next       = bus.cpu_req_i;
        req_next.valid = 1'b1;
      end else begin
        state_next = EMPTY;
        req_next   = '0;
      end
    end else if (state == HOLD_PF && flush_i) begin
      state_next = EMPTY;
      req_next   = '0;
    end
  end

  assign bus.dcache_req_valid_o  = (state != EMPTY);
  assign bus.dcache_req_src_pf_o = (state == HOLD_PF);
  assign bus.dcache_req_o        = req_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt <= '0;
    end else if (!enable_i || flush_i || (load_en && pf_win)) begin
      starve_cnt <= '0;
    end else if (load_en && cpu_win && bus.pf_req_valid_i && !starved) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pf_issued_cnt_o <= '0;
    end else if ((state == HOLD_PF) && bus.dcache_req_ready_i && (pf_issued_cnt_o != 32'hFFFF_FFFF)) begin
      pf_issued_cnt_o <= pf_issued_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_hwpf_arbiter.sv
// tb/tb_hwpf_arbiter.sv - directed self-checking bench for hwpf_arbiter
// Runs with STARVE_MAX=3 so the starvation pattern is C,C,C,P repeating.
module tb_hwpf_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pf_cnt;
  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_cnt = 0;

  always #5 clk = ~clk;

  hwpf_arbiter_if bus();

  hwpf_arbiter #(.STARVE_MAX(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .flush_i(flush),
    .bus(bus), .pf_issued_cnt_o(pf_cnt)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic req_cpu_dcache_t mk(input logic [4:0] rd, input logic [63:0] d, input logic v);
    mk          = '0;
    mk.valid    = v;
    mk.rd       = rd;
    mk.data_rs1 = d;
    mk.addr     = {21'h0, rd, 6'h0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req_valid_i    = 1'b0;
    bus.cpu_req_i          = '0;
    bus.pf_req_valid_i     = 1'b0;
    bus.pf_req_i           = '0;
    bus.dcache_req_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    enable = 1'b1;
    bus.cpu_req_valid_i = 1'b1;
    bus.pf_req_valid_i  = 1'b1;
    bus.dcache_req_ready_i = 1'b1;
    #12;
    n_checks++; if ({bus.cpu_req_ready_o, bus.pf_read_o} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b exp 00", {bus.cpu_req_ready_o, bus.pf_read_o}); end
    n_checks++; if (bus.dcache_req_o !== '0) begin n_fail++; $display("FAIL reset_req: got %h exp 0", bus.dcache_req_o); end
    n_checks++; if (pf_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d exp 0", pf_cnt); end
    idle_inputs();
    enable = 1'b0;
    #4;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({bus.dcache_req_valid_o, bus.dcache_req_src_pf_o, bus.cpu_req_ready_o, bus.pf_read_o} !== 4'b0 || pf_cnt !== 32'd0 || dut.starve_cnt !== 2'd0) begin
        n_fail++; $display("FAIL idle_outputs cycle %0d: got v=%b pf=%b rdy=%b rd=%b cnt=%0d st=%0d exp all 0", i,
          bus.dcache_req_valid_o, bus.dcache_req_src_pf_o, bus.cpu_req_ready_o, bus.pf_read_o, pf_cnt, dut.starve_cnt);
      end
    end
  endtask

  task automatic test_cpu_pass();
    bus.dcache_req_ready_i = 1'b1;
    bus.cpu_req_valid_i = 1'b1;
    bus.cpu_req_i = mk(5'd1, 64'hCAFECAFE, 1'b0);
    #1;
    n_checks++; if ({bus.cpu_req_ready_o, bus.pf_read_o} !== 2'b10) begin n_fail++; $display("FAIL cpu_grant: got %b exp 10", {bus.cpu_req_ready_o, bus.pf_read_o}); end
    tick();
    bus.cpu_req_valid_i = 1'b0;
    bus.cpu_req_i = '0;
    n_checks++; if (bus.dcache_req_o !== mk(5'd1, 64'hCAFECAFE, 1'b1)) begin n_fail++; $display("FAIL cpu_present: got %h exp %h", bus.dcache_req_o, mk(5'd1, 64'hCAFECAFE, 1'b1)); end
    n_checks++; if ({bus.dcache_req_valid_o, bus.dcache_req_src_pf_o} !== 2'b10) begin n_fail++; $display("FAIL cpu_valid_src: got %b exp 10", {bus.dcache_req_valid_o, bus.dcache_req_src_pf_o}); end
    tick();
    n_checks++; if (bus.dcache_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL cpu_drain: got %b exp 0", bus.dcache_req_valid_o); end
  endtask

  task automatic test_prefetch();
    enable = 1'b1;
    bus.dcache_req_ready_i = 1'b1;
    bus.pf_req_valid_i = 1'b1;
    bus.pf_req_i = mk(5'd2, 64'h22, 1'b0);
    #1;
    n_checks++; if ({bus.cpu_req_ready_o, bus.pf_read_o} !== 2'b01) begin n_fail++; $display("FAIL pf_grant: got %b exp 01", {bus.cpu_req_ready_o, bus.pf_read_o}); end
    tick();
    bus.pf_req_valid_i = 1'b0;
    n_checks++; if (bus.dcache_req_o !== mk(5'd2, 64'h22, 1'b1) || bus.dcache_req_src_pf_o !== 1'b1) begin n_fail++; $display("FAIL pf_present: got %h src=%b exp %h src=1", bus.dcache_req_o, bus.dcache_req_src_pf_o, mk(5'd2, 64'h22, 1'b1)); end
    n_checks++; if (pf_cnt !== 32'(exp_cnt)) begin n_fail++; $display("FAIL pf_cnt_before: got %0d exp %0d", pf_cnt, exp_cnt); end
    tick();
    exp_cnt++;
    n_checks++; if (pf_cnt !== 32'(exp_cnt) || bus.dcache_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL pf_cnt_after: got %0d v=%b exp %0d v=0", pf_cnt, bus.dcache_req_valid_o, exp_cnt); end
    enable = 1'b0;
    bus.pf_req_valid_i = 1'b1;
    #1;
    n_checks++; if (bus.pf_read_o !== 1'b0) begin n_fail++; $display("FAIL pf_disabled_read: got %b exp 0", bus.pf_read_o); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if ({bus.dcache_req_valid_o, bus.pf_read_o} !== 2'b00) begin n_fail++; $display("FAIL pf_disabled_empty: got %b exp 00", {bus.dcache_req_valid_o, bus.pf_read_o}); end
    end
    bus.pf_req_valid_i = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_starvation();
    logic pf_exp, prev_pf;
    prev_pf = 1'b0;
    enable = 1'b1;
    bus.dcache_req_ready_i = 1'b1;
    bus.cpu_req_valid_i = 1'b1;
    bus.cpu_req_i = mk(5'd3, 64'h33, 1'b0);
    bus.pf_req_valid_i = 1'b1;
    bus.pf_req_i = mk(5'd4, 64'h44, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      pf_exp = (i % 4 == 0);
      #1;
      n_checks++; if ({bus.cpu_req_ready_o, bus.pf_read_o} !== {~pf_exp, pf_exp}) begin n_fail++; $display("FAIL starve_grant cycle %0d: got %b exp %b", i, {bus.cpu_req_ready_o, bus.pf_read_o}, {~pf_exp, pf_exp}); end
      tick();
      if (prev_pf) exp_cnt++;
      prev_pf = pf_exp;
      n_checks++; if (bus.dcache_req_src_pf_o !== pf_exp || bus.dcache_req_o.rd !== (pf_exp ? 5'd4 : 5'd3) || pf_cnt !== 32'(exp_cnt)) begin
        n_fail++; $display("FAIL starve_held cycle %0d: got src=%b rd=%0d cnt=%0d exp src=%b rd=%0d cnt=%0d", i,
          bus.dcache_req_src_pf_o, bus.dcache_req_o.rd, pf_cnt, pf_exp, pf_exp ? 4 : 3, exp_cnt);
      end
    end
    idle_inputs();
    bus.dcache_req_ready_i = 1'b1;
    tick();
    if (prev_pf) exp_cnt++;
    n_checks++; if (pf_cnt !== 32'(exp_cnt) || bus.dcache_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL starve_drain: got cnt=%0d v=%b exp cnt=%0d v=0", pf_cnt, bus.dcache_req_valid_o, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    bus.dcache_req_ready_i = 1'b1;
    bus.cpu_req_valid_i = 1'b1;
    bus.cpu_req_i = mk(5'd5, 64'h55, 1'b0);
    bus.pf_req_valid_i = 1'b1;
    bus.pf_req_i = mk(5'd6, 64'h66, 1'b0);
    #1;
    n_checks++; if (bus.cpu_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_first_grant: got %b exp 1", bus.cpu_req_ready_o); end
    tick();
    bus.dcache_req_ready_i = 1'b0;
    bus.cpu_req_i = mk(5'd8, 64'h88, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if ({bus.cpu_req_ready_o, bus.pf_read_o} !== 2'b00 || bus.dcache_req_o !== mk(5'd5, 64'h55, 1'b1) || dut.starve_cnt !== 2'd1) begin
        n_fail++; $display("FAIL bp_hold cycle %0d: got rdy=%b rd=%b req=%h st=%0d exp 0 0 %h 1", i,
          bus.cpu_req_ready_o, bus.pf_read_o, bus.dcache_req_o, dut.starve_cnt, mk(5'd5, 64'h55, 1'b1));
      end
      tick();
    end
    bus.dcache_req_ready_i = 1'b1;
    #1;
    n_checks++; if ({bus.cpu_req_ready_o, bus.pf_read_o} !== 2'b10 || bus.dcache_req_o.rd !== 5'd5) begin n_fail++; $display("FAIL bp_release: got %b rd=%0d exp 10 rd=5", {bus.cpu_req_ready_o, bus.pf_read_o}, bus.dcache_req_o.rd); end
    tick();
    n_checks++; if (bus.dcache_req_o !== mk(5'd8, 64'h88, 1'b1) || bus.dcache_req_src_pf_o !== 1'b0 || dut.starve_cnt !== 2'd2) begin
      n_fail++; $display("FAIL bp_reload: got %h src=%b st=%0d exp %h src=0 st=2", bus.dcache_req_o, bus.dcache_req_src_pf_o, dut.starve_cnt, mk(5'd8, 64'h88, 1'b1));
    end
    idle_inputs();
    bus.dcache_req_ready_i = 1'b1;
    tick();
    n_checks++; if (bus.dcache_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b exp 0", bus.dcache_req_valid_o); end
  endtask

  task automatic test_flush_pf();
    idle_inputs();
    enable = 1'b1;
    bus.pf_req_valid_i = 1'b1;
    bus.pf_req_i = mk(5'd7, 64'h77, 1'b0);
    #1;
    n_checks++; if (bus.pf_read_o !== 1'b1) begin n_fail++; $display("FAIL fpf_grant: got %b exp 1", bus.pf_read_o); end
    tick();
    bus.pf_req_valid_i = 1'b0;
    tick();
    n_checks++; if (bus.dcache_req_o !== mk(5'd7, 64'h77, 1'b1) || bus.dcache_req_src_pf_o !== 1'b1) begin n_fail++; $display("FAIL fpf_held: got %h src=%b exp %h src=1", bus.dcache_req_o, bus.dcache_req_src_pf_o, mk(5'd7, 64'h77, 1'b1)); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (bus.dcache_req_valid_o !== 1'b0 || bus.dcache_req_o !== '0 || pf_cnt !== 32'(exp_cnt)) begin
      n_fail++; $display("FAIL fpf_dropped: got v=%b req=%h cnt=%0d exp v=0 req=0 cnt=%0d", bus.dcache_req_valid_o, bus.dcache_req_o, pf_cnt, exp_cnt);
    end
    bus.dcache_req_ready_i = 1'b1;
    tick();
    n_checks++; if (pf_cnt !== 32'(exp_cnt)) begin n_fail++; $display("FAIL fpf_cnt_later: got %0d exp %0d", pf_cnt, exp_cnt); end
  endtask

  task automatic test_flush_cpu();
    idle_inputs();
    bus.cpu_req_valid_i = 1'b1;
    bus.cpu_req_i = mk(5'd9, 64'h99, 1'b0);
    #1;
    n_checks++; if (bus.cpu_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL fcpu_grant: got %b exp 1", bus.cpu_req_ready_o); end
    tick();
    bus.cpu_req_valid_i = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (bus.dcache_req_o !== mk(5'd9, 64'h99, 1'b1) || bus.dcache_req_src_pf_o !== 1'b0) begin n_fail++; $display("FAIL fcpu_kept: got %h src=%b exp %h src=0", bus.dcache_req_o, bus.dcache_req_src_pf_o, mk(5'd9, 64'h99, 1'b1)); end
    bus.dcache_req_ready_i = 1'b1;
    tick();
    n_checks++; if (bus.dcache_req_valid_o !== 1'b0 || pf_cnt !== 32'(exp_cnt)) begin n_fail++; $display("FAIL fcpu_accepted: got v=%b cnt=%0d exp v=0 cnt=%0d", bus.dcache_req_valid_o, pf_cnt, exp_cnt); end
  endtask

  task automatic test_flush_load();
    bus.dcache_req_ready_i = 1'b1;
    flush = 1'b1;
    bus.cpu_req_valid_i = 1'b1;
    bus.cpu_req_i = mk(5'd10, 64'hAA, 1'b0);
    bus.pf_req_valid_i = 1'b1;
    bus.pf_req_i = mk(5'd11, 64'hBB, 1'b0);
    #1;
    n_checks++; if ({bus.cpu_req_ready_o, bus.pf_read_o} !== 2'b10) begin n_fail++; $display("FAIL fload_grant: got %b exp 10", {bus.cpu_req_ready_o, bus.pf_read_o}); end
    tick();
    flush = 1'b0;
    n_checks++; if (bus.dcache_req_o.rd !== 5'd10 || bus.dcache_req_src_pf_o !== 1'b0 || dut.starve_cnt !== 2'd0) begin
      n_fail++; $display("FAIL fload_held: got rd=%0d src=%b st=%0d exp rd=10 src=0 st=0", bus.dcache_req_o.rd, bus.dcache_req_src_pf_o, dut.starve_cnt);
    end
    idle_inputs();
    bus.dcache_req_ready_i = 1'b1;
    tick();
  endtask

  task automatic test_flush_accept();
    idle_inputs();
    bus.pf_req_valid_i = 1'b1;
    bus.pf_req_i = mk(5'd13, 64'hDD, 1'b0);
    tick();
    bus.pf_req_valid_i = 1'b0;
    bus.dcache_req_ready_i = 1'b1;
    flush = 1'b1;
    bus.cpu_req_valid_i = 1'b1;
    bus.cpu_req_i = mk(5'd12, 64'hCC, 1'b0);
    #1;
    n_checks++; if ({bus.cpu_req_ready_o, bus.pf_read_o} !== 2'b10) begin n_fail++; $display("FAIL facc_grant: got %b exp 10", {bus.cpu_req_ready_o, bus.pf_read_o}); end
    tick();
    flush = 1'b0;
    bus.cpu_req_valid_i = 1'b0;
    exp_cnt++;
    n_checks++; if (pf_cnt !== 32'(exp_cnt) || bus.dcache_req_o.rd !== 5'd12 || bus.dcache_req_src_pf_o !== 1'b0) begin
      n_fail++; $display("FAIL facc_counted: got cnt=%0d rd=%0d src=%b exp cnt=%0d rd=12 src=0", pf_cnt, bus.dcache_req_o.rd, bus.dcache_req_src_pf_o, exp_cnt);
    end
    tick();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    bus.cpu_req_valid_i = 1'b1;
    bus.cpu_req_i = mk(5'd14, 64'hEE, 1'b0);
    tick();
    n_checks++; if (bus.dcache_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL arst_loaded: got %b exp 1", bus.dcache_req_valid_o); end
    #3;
    rst_n = 1'b0;
    exp_cnt = 0;
    #1;
    n_checks++; if (bus.dcache_req_valid_o !== 1'b0 || bus.dcache_req_o !== '0 || bus.cpu_req_ready_o !== 1'b0 || pf_cnt !== 32'(exp_cnt)) begin
      n_fail++; $display("FAIL arst_dropped: got v=%b req=%h rdy=%b cnt=%0d exp 0", bus.dcache_req_valid_o, bus.dcache_req_o, bus.cpu_req_ready_o, pf_cnt);
    end
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.dcache_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_after: got %b exp 0", bus.dcache_req_valid_o); end
  endtask

  initial begin
    test_reset();
    test_cpu_pass();
    test_prefetch();
    test_starvation();
    test_back_to_back();
    test_flush_pf();
    test_flush_cpu();
    test_flush_load();
    test_flush_accept();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hwpf_arbiter.md
# hwpf_arbiter

Request arbiter that sits directly downstream of the next-line prefetch FIFO (`hwpf_fifo`) and in front of the HPDcache request port. Each cycle it picks between the CPU demand request and the oldest queued prefetch request, and loads the winner into a one-entry output register. That register presents the request to the dcache with a valid/ready handshake. CPU demand requests win by default; a starvation counter guarantees prefetch forward progress. A flush discards prefetch work without disturbing demand traffic.

## Interface
- `STARVE_MAX`, default 15: number of consecutive lost arbitrations after which a waiting prefetch wins. Legal range ≥1.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `enable_i`  in  1  prefetch enable. When 0, prefetch is never granted and `starve_cnt` is held at 0.
- `flush_i`  in  1  drops a held prefetch and suppresses prefetch pops this cycle.
- `cpu_req_valid_i`  in  1  CPU demand request valid.
- `cpu_req_i`  in  `$bits(req_cpu_dcache_t)`  CPU demand request.
- `cpu_req_ready_o`  out  1  CPU request accepted this cycle (combinational).
- `pf_req_valid_i`  in  1  prefetch FIFO non-empty; connects to FIFO `arbiter_req_valid_o`.
- `pf_req_i`  in  `$bits(req_cpu_dcache_t)`  head of prefetch FIFO.
- `pf_read_o`  out  1  pop strobe to FIFO `read_i` (combinational).
- `dcache_req_valid_o`  out  1  registered request valid.
- `dcache_req_o`  out  `$bits(req_cpu_dcache_t)`  registered request. Its `.valid` field equals `dcache_req_valid_o`.
- `dcache_req_src_pf_o`  out  1  held request originated from a prefetch.
- `dcache_req_ready_i`  in  1  dcache accepts the held request.
- `pf_issued_cnt_o`  out  32  saturating count of prefetches accepted by the dcache.

## Operation
- State is the output register occupancy:
  - EMPTY
  - HOLD_CPU
  - HOLD_PF
- `load_en = ~dcache_req_valid_o | dcache_req_ready_i`.
- Grant, evaluated only when `load_en`:
  - `pf_win = pf_req_valid_i & enable_i & ~flush_i & (~cpu_req_valid_i | starve_cnt == STARVE_MAX)`.
  - `cpu_win = cpu_req_valid_i & ~pf_win`.
- Outputs:
  - `cpu_req_ready_o = load_en & cpu_win`.
  - `pf_read_o = load_en & pf_win`.
- Next state:
  - If `pf_win`: go to HOLD_PF and load `pf_req_i`.
  - Else if `cpu_win`: go to HOLD_CPU and load `cpu_req_i`.
  - Else if `load_en`: go to EMPTY.
  - Otherwise (held request with `dcache_req_ready_i` low): hold; the output is bit-stable.
- Flush:
  - `flush_i` in HOLD_PF with `dcache_req_ready_i` low: the register is cleared to EMPTY next cycle. No dcache handshake occurs and `pf_issued_cnt_o` is not incremented.
  - `flush_i` in HOLD_CPU: no effect.
  - `flush_i` with `load_en` high: a CPU request may still be loaded that cycle.
- `starve_cnt`, width `$clog2(STARVE_MAX+1)`:
  - Cleared on reset, on `pf_win`, when `enable_i`=0, and on `flush_i`.
  - Otherwise increments on `load_en & cpu_win & pf_req_valid_i`, saturating at STARVE_MAX.
- `pf_issued_cnt_o` increments on `dcache_req_valid_o & dcache_req_ready_i & dcache_req_src_pf_o` and saturates at `32'hFFFF_FFFF`.
- Simultaneous events:
  - Accept of the held request and load of a new one in the same cycle gives full throughput.
  - Flush together with an accepted HOLD_PF request: the accept is counted, then the register follows the normal load rule.

## Timing
- Reset values: `dcache_req_valid_o`=0, `dcache_req_o`='0, `dcache_req_src_pf_o`=0, `pf_issued_cnt_o`=0, `starve_cnt`=0, state EMPTY.
- Combinational outputs are 0 whenever their inputs are 0.
- Latency: a request granted in cycle N is presented in cycle N+1.
- Throughput: one request per cycle while `dcache_req_ready_i`=1.
- `cpu_req_ready_o` and `pf_read_o` depend combinationally on `dcache_req_ready_i`, the valids, `enable_i`, `flush_i` and `starve_cnt`. No path from the request payloads.
- Asynchronous reset mid-transfer drops the held request immediately. No pop or ready is asserted while `rst_ni`=0.

## Test plan
- Reset / idle: `rst_ni`=0 then 1 with all valids 0 → all outputs 0 for 5 cycles; `pf_read_o`=0 and `cpu_req_ready_o`=0.
- CPU pass-through: CPU request rd=1, data_rs1=64'hCAFECAFE, `dcache_req_ready_i`=1 → `cpu_req_ready_o`=1 that cycle; next cycle `dcache_req_valid_o`=1, rd=1, data_rs1=64'hCAFECAFE, `src_pf`=0.
- Prefetch only: `enable_i`=1, pf rd=2 valid → `pf_read_o`=1 for one cycle; next cycle `src_pf`=1, rd=2; `pf_issued_cnt_o`=1 after the accept. Repeat with `enable_i`=0 → `pf_read_o` stays 0 and the output stays empty.
- Starvation, `STARVE_MAX`=3, both sources continuously valid, ready=1 → grant sequence C,C,C,P,C,C,C,P; `pf_read_o` high exactly on cycles 4 and 8.
- Backpressure: HOLD_CPU with rd=5 and `dcache_req_ready_i`=0 for 4 cycles while both sources are valid → output bit-stable, `cpu_req_ready_o`=0, `pf_read_o`=0, `starve_cnt` unchanged; on release rd=5 is accepted and the next grant is loaded the same cycle.
- Flush:
  - HOLD_PF with rd=7, ready=0, `flush_i`=1 for one cycle → `dcache_req_valid_o`=0 next cycle and `pf_issued_cnt_o` unchanged.
  - Same stimulus in HOLD_CPU → the request is kept and accepted later.
